// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative unsigned multiply/divide unit that owns the HI/LO register pair.
//   MULTU uses LSB-first shift-add, DIVU uses MSB-first restoring division.
//   Both take WIDTH cycles.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start, op_div : request a new op (0 = MULTU, 1 = DIVU), accepted in IDLE
//   abort         : synchronous cancel of the in-flight op; wins over start
//   opa, opb      : rs / rt operands, latched when start is accepted
//   lh_sel        : 01 = read LO, 10 = read HI onto lh_out (combinational)
//   hi, lo        : architectural HI/LO registers
//   busy          : op in progress
//   done          : one-cycle pulse in the cycle after HI/LO commit
//   div_zero      : last DIVU had a zero divisor
//   stall         : busy and a new HI/LO op or HI/LO read is presented
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             abort,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [1:0]       lh_sel,
  output logic [WIDTH-1:0] lh_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic [WIDTH-1:0]   opb_q;
  // Shared working register: MULTU accumulator {upper, lower},
  // DIVU {rem, quot}. Both start as {0, opa}.
  logic [2*WIDTH-1:0] wk;
  logic [2*WIDTH-1:0] wk_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;

  always_comb begin
    mul_sum = {1'b0, wk[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    rem_sh  = {wk[2*WIDTH-1:WIDTH], wk[WIDTH-1]};
    trial   = {1'b0, rem_sh} - {2'b00, opb_q};
    wk_next = wk;
    if (is_div) begin
      // The shifted remainder is kept one bit wider so the restoring
      // compare is exact. The trial remainder is always below opb, so it
      // fits back into WIDTH bits.
      if (trial[WIDTH+1])
        wk_next = {rem_sh[WIDTH-1:0], wk[WIDTH-2:0], 1'b0};
      else
        wk_next = {trial[WIDTH-1:0], wk[WIDTH-2:0], 1'b1};
    end else begin
      // The carry-out of the add becomes the MSB after the right shift.
      if (wk[0])
        wk_next = {mul_sum, wk[WIDTH-1:1]};
      else
        wk_next = {1'b0, wk[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      opb_q    <= '0;
      wk       <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= RUN;
            count    <= '0;
            is_div   <= op_div;
            opb_q    <= opb;
            wk       <= {{WIDTH{1'b0}}, opa};
            div_zero <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            wk    <= wk_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              hi       <= wk_next[2*WIDTH-1:WIDTH];
              lo       <= wk_next[WIDTH-1:0];
              div_zero <= is_div && (opb_q == '0);
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign stall = busy & (start | (lh_sel == 2'b01) | (lh_sel == 2'b10));

  always_comb begin
    lh_out = '0;
    case (lh_sel)
      2'b01:   lh_out = lo;
      2'b10:   lh_out = hi;
      default: lh_out = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus randomized
// MULTU/DIVU traffic compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [1:0]   lh_sel = '0;
  logic [W-1:0] lh_out, hi, lo;
  logic         busy, done, div_zero, stall;

  int checks = 0;
  int failures = 0;

  // Reference architectural state
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;
  logic         mdz = 1'b0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .abort(abort),
    .opa(opa), .opb(opb), .lh_sel(lh_sel), .lh_out(lh_out), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input bit div, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    if (div) begin
      if (b == 0) begin
        mlo = '1;
        mhi = a;
        mdz = 1'b1;
      end else begin
        mlo = a / b;
        mhi = a % b;
        mdz = 1'b0;
      end
    end else begin
      p   = {32'b0, a} * {32'b0, b};
      mhi = p[63:32];
      mlo = p[31:0];
      mdz = 1'b0;
    end
  endfunction

  // Called in the low clock phase; returns at the negedge after commit
  // (done cycle) or, when aborted, W cycles after the abort.
  task automatic do_op(input bit div, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int abort_at, input bit stress);
    int busy_cnt;
    int dn;
    bit exp_stall;
    busy_cnt = 0;
    op_div = div; opa = a; opb = b; start = 1'b1; abort = 1'b0; lh_sel = 2'b00;
    #1 chk("stall_idle", stall, 0);
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom;
    mdz = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == 0) begin
        chk("done_one_cycle", done, 0);
        chk("div_zero_cleared", div_zero, 0);
      end
      if (busy) busy_cnt++;
      if (stress) begin
        lh_sel = 2'($urandom_range(0, 3));
        start  = 1'($urandom_range(0, 1));
        op_div = 1'($urandom_range(0, 1));
        opa = $urandom; opb = $urandom;
        #1;
        exp_stall = start || (lh_sel == 2'b01) || (lh_sel == 2'b10);
        chk("stall_busy", stall, exp_stall);
        chk("lh_out_busy", lh_out, (lh_sel == 2'b01) ? mlo : (lh_sel == 2'b10) ? mhi : '0);
      end
      if (i == abort_at) abort = 1'b1;
      @(negedge clk);
      start = 1'b0; lh_sel = 2'b00; abort = 1'b0;
      if (i == abort_at) begin
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, mhi);
        chk("abort_lo", lo, mlo);
        chk("abort_dz", div_zero, mdz);
        dn = 0;
        repeat (W) begin
          if (done) dn++;
          @(negedge clk);
        end
        chk("abort_no_done", dn, 0);
        chk("abort_hi_late", hi, mhi);
        return;
      end
    end
    chk("busy_cycles", busy_cnt, W);
    chk("busy_end", busy, 0);
    chk("done_pulse", done, 1);
    ref_op(div, a, b);
    chk("hi", hi, mhi);
    chk("lo", lo, mlo);
    chk("div_zero", div_zero, mdz);
    lh_sel = 2'b01;
    #1 chk("lh_lo_done", lh_out, mlo);
    chk("stall_done", stall, 0);
    lh_sel = 2'b10;
    #1 chk("lh_hi_done", lh_out, mhi);
    lh_sel = 2'b00;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rd;
    int           rab;

    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    do_op(1'b1, 32'd100, 32'd7, -1, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'd0, -1, 1'b0);
    do_op(1'b0, 32'd3, 32'd5, -1, 1'b1);
    do_op(1'b1, 32'd9, 32'd2, -1, 1'b1);
    do_op(1'b0, 32'd7, 32'd6, 20, 1'b0);
    do_op(1'b0, 32'd7, 32'd6, int'(W) - 1, 1'b0);

    // abort and start together in IDLE: start dropped
    start = 1'b1; abort = 1'b1; op_div = 1'b0; opa = 32'd3; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", busy, 0);
    @(negedge clk);
    chk("abort_start_idle_lo", lo, mlo);

    for (int n = 0; n < 20; n++) begin
      rd = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      rab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      do_op(rd, ra, rb, rab, 1'b1);
    end

    // make HI/LO nonzero, then reset asynchronously mid-run
    do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF1, -1, 1'b0);
    op_div = 1'b0; opa = 32'd5; opb = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    rst_n = 1'b1;
    mhi = '0; mlo = '0; mdz = 1'b0;
    @(negedge clk);
    do_op(1'b0, 32'd2, 32'd2, -1, 1'b0);
    @(negedge clk);
    chk("final_done_low", done, 0);
    chk("final_lo", lo, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Iterative unsigned multiply/divide unit with the architectural HI/LO register pair. It sits downstream of the instruction decoder and consumes its ToLH, AluOP-derived op select and LHToReg signals, together with register-file operands. It executes MULTU (shift-add) and DIVU (restoring) in WIDTH cycles. It raises a stall to the pipeline when a new HI/LO op or an MFHI/MFLO arrives while busy.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  decoder ToLH qualified by a valid instruction; request a new operation
op_div  in  1  0 = MULTU, 1 = DIVU; sampled with start
abort  in  1  synchronous cancel of the in-flight operation (pipeline flush)
opa  in  WIDTH  rs value: multiplicand or dividend
opb  in  WIDTH  rt value: multiplier or divisor
lh_sel  in  2  LHToReg: 01 = read LO, 10 = read HI, 00/11 = no read
lh_out  out  WIDTH  combinational: LO if lh_sel=01, HI if 10, else 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  high while an operation is in RUN
done  out  1  one-cycle pulse in the cycle after HI/LO commit
div_zero  out  1  last DIVU had divisor 0; held until the next accepted start
stall  out  1  combinational: busy & (start | lh_sel==01 | lh_sel==10)

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; hi=lo=0; busy=done=div_zero=0; counter and working registers cleared. Reset mid-RUN discards the operation and leaves no partial HI/LO write.
- FSM states: IDLE, RUN.
- IDLE to RUN at edge E0 when start=1:
  - latch opa, opb, op_div; count=0; clear div_zero.
  - MULTU: acc = {WIDTH'b0, opa}.
  - DIVU: rem=0, quot=opa.
- RUN, one iteration per edge E1..E_WIDTH:
  - MULTU (LSB-first shift-add): if acc[0], add opb into upper half with carry-out kept (WIDTH+1 bits). Then shift the whole acc right by 1.
  - DIVU (restoring, MSB-first): shift {rem,quot} left by 1. Compute trial = rem - opb in WIDTH+1 bits. If trial is non-negative, rem = trial and quot[0]=1; else quot[0]=0.
- At edge E_WIDTH (count==WIDTH-1):
  - MULTU commits hi=acc[2W-1:W], lo=acc[W-1:0].
  - DIVU commits lo=quot, hi=rem; div_zero=1 if the latched opb==0.
  - State returns to IDLE; done=1 for exactly one cycle.
- Latency: busy is high for exactly WIDTH cycles; new HI/LO is visible from edge E_WIDTH. Unit throughput is one op per WIDTH cycles; a start in the done cycle is accepted (back-to-back).
- Divide by zero uses the same WIDTH-cycle path with no special-casing of the arithmetic. Result: lo = all ones, hi = opa. No exception is raised.
- start while busy: not accepted; operands are ignored. stall is high, so the pipeline holds the instruction and re-presents it.
- lh_sel nonzero while busy: stall=1 and lh_out returns the old HI/LO. The pipeline must not consume it.
- lh_sel nonzero in IDLE: lh_out reflects the current HI/LO with zero latency. A read in the done cycle sees the new values.
- abort in RUN: at the next edge, state=IDLE, busy=0, no commit, no done pulse; HI/LO and div_zero unchanged.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- abort on edge E_WIDTH: abort wins; no commit.
- opa/opb may change freely after E0; the unit uses only latched copies.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high for 32 cycles; at E32 hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- DIVU 100 / 7 -> lo=14, hi=2, div_zero=0. Then DIVU 0x80000000 / 0 -> lo=0xFFFFFFFF, hi=0x80000000, div_zero=1.
- MULTU 3 x 5 started; lh_sel=10 asserted at cycle 10 -> stall=1, lh_out=old HI. After done, lh_sel=01 -> lh_out=15, stall=0.
- start (DIVU 9/2) during a busy MULTU -> ignored, stall=1, MULTU result unaffected. Re-presented start in the done cycle -> accepted; lo=4, hi=1 after 32 more cycles.
- abort at cycle 20 of MULTU 7 x 6 -> busy drops next edge, no done pulse, hi/lo keep prior values.
- rst_n low for 1 ns mid-RUN (asynchronous, off clock edge) -> hi=lo=0, busy=0 immediately. After release, a MULTU 2 x 2 completes normally with lo=4.
